seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Receive-side counterpart of the BCD->7-segment decoder. Monitors a multiplexed, active-low
//  7-segment display bus (segment lines plus digit strobes) and recovers per-digit BCD values.
//  A pattern is accepted only after it has been stable for STABLE_CYC cycles.
//  Delivers one complete display frame to a downstream consumer over a valid/ready handshake.
//  Used to self-check display output and to read back values for the control logic.
// PARAMETERS
//  NDIG        4  number of multiplexed digits (digit strobes); 2..8
//  STABLE_CYC  4  consecutive identical samples required before capture; 2..255
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       synchronous reset, active low
//  seg_n      in   7       segment lines {g,f,e,d,c,b,a}, active low (0 = segment lit)
//  dig_n      in   NDIG    digit strobes, active low; exactly one low = valid selection
//  bcd_out    out  4*NDIG  frame BCD; digit i in bits [4i+3:4i]
//  blank_out  out  NDIG    per digit: blank pattern captured
//  err_out    out  NDIG    per digit: unrecognised pattern captured
//  out_valid  out  1       frame available; held until accepted
//  out_ready  in   1       consumer accepts the frame when out_valid && out_ready
// BEHAVIOUR
//  Reset: one clock is used, and reset is synchronous and active low.
//   - While rst_n is low at a clk edge: bcd_out, blank_out, err_out and out_valid are 0.
//   - Stable counter, capture mask, working regs and both FSMs are cleared.
//   - Reset mid-frame discards all partial captures.
//  Input stage: seg_n and dig_n are registered once (1 cycle). All rules below use the
//   registered copies.
//  Encoding (active low, {g..a}):
//   - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x18.
//   - 0x7F -> bcd 0xF, blank=1.
//   - Any other code -> bcd 0xF, err=1.
//  Capture FSM:
//   - HUNT: selection not valid (zero or more than one strobe low). Counter held at 0.
//     A valid selection moves to SETTLE with count=1.
//   - SETTLE: if seg and dig are equal to the previous cycle, count++; any change sets
//     count=1 (or goes to HUNT if the selection is now invalid).
//     When count==STABLE_CYC, write the encoded digit into working slot i (i = index of
//     the low strobe), set mask[i], then go to HELD.
//   - HELD: no further writes. Any change of seg or dig goes to SETTLE (count=1), or to
//     HUNT if the selection is invalid.
//   - Capture latency: the write occurs STABLE_CYC cycles after the first registered
//     sample of a stable pattern.
//   - The same digit captured again before the frame completes overwrites its slot
//     (last value wins).
//  Frame / output FSM (EMPTY, FULL):
//   - When mask is all ones, the frame completes: mask clears in the same cycle.
//   - EMPTY: the frame is copied to the outputs and out_valid=1 from the next cycle (FULL).
//   - FULL: outputs are frozen while out_valid && !out_ready. Accept returns to EMPTY and
//     out_valid=0 next cycle, unless a frame completes in the same cycle; then the new
//     frame loads and out_valid stays 1.
//   - A frame completing in FULL without accept is dropped (mask cleared, outputs unchanged).
//  Arithmetic: counter width is clog2(STABLE_CYC+1) and saturates at STABLE_CYC.
//   No wrap-around.
// STRUCTURE
//  - Package seg7_pkg holds the constants SEG_0..SEG_9, SEG_BLANK=7'h7F and BCD_BLANK=4'hF.
//    The decoder side shares these constants.
//  - Sub-module seg7_pattern_encoder: combinational seg_n[6:0] -> {bcd[3:0], blank, err}.
//  - The top holds the input flops, capture FSM, stable counter, working regs, mask and
//    output FSM/regs.
// TESTING
//  1) NDIG=4, STABLE_CYC=4. Drive digits 3..0 = 0x30/0x24/0x79/0x40, each held 6 cycles.
//     -> bcd_out=16'h3210, blank/err=0. out_valid rises 1 cycle after the last capture.
//  2) Digit 0 pattern 0x12 held only 3 cycles, then 0x02 held 5 cycles -> digit 0 = 6.
//     Exactly one write occurs.
//  3) Digit 2 = 0x7F, digit 1 = 0x55 -> blank_out=4'b0100, err_out=4'b0010,
//     both nibbles = 0xF.
//  4) dig_n=4'b0000 or 4'b1111 for 20 cycles -> no capture; mask unchanged.
//  5) out_ready=0 while a second frame completes -> first frame held and second dropped.
//     Then assert out_ready in the same cycle a third frame completes -> third frame
//     loads; out_valid never drops.
//  6) rst_n=0 for 1 cycle with 3 digits captured -> all outputs 0.
//     The next frame needs all 4 digits captured again.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_pkg : shared 7-segment codes, decode result type and FSM encodings   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package seg7_pkg;

    // Active-low segment codes {g,f,e,d,c,b,a}; the decoder side uses the same table
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef struct packed {
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } seg7_dec_t;

    localparam logic [1:0] CAP_HUNT   = 2'd0;
    localparam logic [1:0] CAP_SETTLE = 2'd1;
    localparam logic [1:0] CAP_HELD   = 2'd2;

    localparam logic OUT_EMPTY = 1'b0;
    localparam logic OUT_FULL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_pattern_encoder : active-low segment pattern -> {bcd, blank, err}   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seg7_pattern_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output seg7_dec_t  dec_o
);

    always_comb begin
        dec_o = '{bcd: BCD_BLANK, blank: 1'b0, err: 1'b1};
        case (seg_n_i)
            SEG_0:     dec_o = '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
            SEG_1:     dec_o = '{bcd: 4'd1, blank: 1'b0, err: 1'b0};
            SEG_2:     dec_o = '{bcd: 4'd2, blank: 1'b0, err: 1'b0};
            SEG_3:     dec_o = '{bcd: 4'd3, blank: 1'b0, err: 1'b0};
            SEG_4:     dec_o = '{bcd: 4'd4, blank: 1'b0, err: 1'b0};
            SEG_5:     dec_o = '{bcd: 4'd5, blank: 1'b0, err: 1'b0};
            SEG_6:     dec_o = '{bcd: 4'd6, blank: 1'b0, err: 1'b0};
            SEG_7:     dec_o = '{bcd: 4'd7, blank: 1'b0, err: 1'b0};
            SEG_8:     dec_o = '{bcd: 4'd8, blank: 1'b0, err: 1'b0};
            SEG_9:     dec_o = '{bcd: 4'd9, blank: 1'b0, err: 1'b0};
            SEG_BLANK: dec_o = '{bcd: BCD_BLANK, blank: 1'b1, err: 1'b0};
            default:   dec_o = '{bcd: BCD_BLANK, blank: 1'b0, err: 1'b1};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_capture : recovers BCD frames from a multiplexed 7-seg bus and  |
// | hands each complete frame downstream over valid/ready.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   dig_n,
    output logic [4*NDIG-1:0] bcd_out,
    output logic [NDIG-1:0]   blank_out,
    output logic [NDIG-1:0]   err_out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int               CNT_W   = $clog2(STABLE_CYC + 1);
    localparam int               IDX_W   = $clog2(NDIG);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [6:0]            seg_q, seg_prev_q;
    logic [NDIG-1:0]       dig_q, dig_prev_q;
    logic [1:0]            cap_state_q, cap_state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NDIG-1:0][3:0]  wbcd_q;
    logic [NDIG-1:0]       wblank_q, werr_q;
    logic [NDIG-1:0]       mask_q, mask_d;
    logic                  out_state_q, out_state_d;
    logic [4*NDIG-1:0]     bcd_q;
    logic [NDIG-1:0]       blank_q, err_q;

    logic                  w_sel_valid;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_same;
    logic                  w_cap_we;
    logic                  w_frame_done;
    logic                  w_out_load;
    seg7_dec_t             w_dec;

    // Input stage plus one cycle of history for the stability comparison
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q      <= SEG_BLANK;
            dig_q      <= '1;
            seg_prev_q <= SEG_BLANK;
            dig_prev_q <= '1;
        end else begin
            seg_q      <= seg_n;
            dig_q      <= dig_n;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
        end
    end

    always_comb begin
        w_sel_valid = ($countones(~dig_q) == 1);
        w_sel_idx   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!dig_q[i]) w_sel_idx = IDX_W'(i);
        end
        w_same = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
    end

    seg7_pattern_encoder u_enc (
        .seg_n_i (seg_q),
        .dec_o   (w_dec)
    );

    // Capture FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_state_q <= CAP_HUNT;
            cnt_q       <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        cap_state_d = cap_state_q;
        cnt_d       = cnt_q;
        if (!w_sel_valid) begin
            cap_state_d = CAP_HUNT;
            cnt_d       = '0;
        end else begin
            case (cap_state_q)
                CAP_HUNT: begin
                    cap_state_d = CAP_SETTLE;
                    cnt_d       = CNT_ONE;
                end
                CAP_SETTLE: begin
                    if (w_same) begin
                        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = CNT_ONE;
                    end
                    if (cnt_d == CNT_MAX) cap_state_d = CAP_HELD;
                end
                CAP_HELD: begin
                    if (!w_same) begin
                        cap_state_d = CAP_SETTLE;
                        cnt_d       = CNT_ONE;
                    end
                end
                default: begin
                    cap_state_d = CAP_HUNT;
                    cnt_d       = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_cap_we = (cap_state_q == CAP_SETTLE) && (cap_state_d == CAP_HELD);
    end

    // Working slots and mask; a completing frame clears the mask in the same cycle
    always_comb begin
        w_frame_done = &mask_q;
        mask_d       = w_frame_done ? '0 : mask_q;
        if (w_cap_we) mask_d[w_sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbcd_q   <= '0;
            wblank_q <= '0;
            werr_q   <= '0;
            mask_q   <= '0;
        end else begin
            mask_q <= mask_d;
            if (w_cap_we) begin
                wbcd_q[w_sel_idx]   <= w_dec.bcd;
                wblank_q[w_sel_idx] <= w_dec.blank;
                werr_q[w_sel_idx]   <= w_dec.err;
            end
        end
    end

    // Output FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_state_q <= OUT_EMPTY;
        end else begin
            out_state_q <= out_state_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            OUT_EMPTY: if (w_frame_done) out_state_d = OUT_FULL;
            OUT_FULL:  if (out_ready && !w_frame_done) out_state_d = OUT_EMPTY;
            default:   out_state_d = OUT_EMPTY;
        endcase
    end

    always_comb begin
        w_out_load = w_frame_done && ((out_state_q == OUT_EMPTY) || out_ready);
        out_valid  = (out_state_q == OUT_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            blank_q <= '0;
            err_q   <= '0;
        end else if (w_out_load) begin
            bcd_q   <= wbcd_q;
            blank_q <= wblank_q;
            err_q   <= werr_q;
        end
    end

    assign bcd_out   = bcd_q;
    assign blank_out = blank_q;
    assign err_out   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg7_scan_capture : directed + random stimulus against a run-length    |
// | reference model of the scan capture. Rev 1.0                             |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_capture;

    localparam int NDIG = 4;
    localparam int S    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic        out_ready = 1'b0;
    wire  [15:0] bcd_out;
    wire  [3:0]  blank_out;
    wire  [3:0]  err_out;
    wire         out_valid;

    seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .dig_n     (dig_n),
        .bcd_out   (bcd_out),
        .blank_out (blank_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: run length of identical valid samples, slots, mask, output frame
    int          run;
    logic [6:0]  pend_seg, last_seg;
    logic [3:0]  pend_dig, last_dig;
    logic [3:0]  m_sbcd [4];
    logic        m_sblank [4];
    logic        m_serr [4];
    logic [3:0]  m_mask;
    logic        m_valid;
    logic [15:0] m_bcd;
    logic [3:0]  m_blank, m_err;
    bit          rdy_on_done = 0;
    bit          track_valid = 0;
    bit          valid_dropped = 0;

    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        logic [6:0] codes [10];
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
        for (int i = 0; i < 10; i++) if (s == codes[i]) return {4'(i), 2'b00};
        if (s == 7'h7F) return {4'hF, 2'b10};
        return {4'hF, 2'b01};
    endfunction

    function automatic int sel_index(input logic [3:0] d);
        if ($countones(~d) != 1) return -1;
        for (int i = 0; i < NDIG; i++) if (!d[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0;
        pend_seg = 7'h7F; last_seg = 7'h7F;
        pend_dig = 4'hF;  last_dig = 4'hF;
        for (int i = 0; i < NDIG; i++) begin
            m_sbcd[i] = 4'h0; m_sblank[i] = 1'b0; m_serr[i] = 1'b0;
        end
        m_mask = 4'h0; m_valid = 1'b0; m_bcd = 16'h0; m_blank = 4'h0; m_err = 4'h0;
    endtask

    task automatic tick();
        int idx;
        logic [5:0] dec;
        bit auto_rdy;
        auto_rdy = 0;
        if (rdy_on_done && m_mask == 4'hF) begin
            out_ready = 1'b1;
            rdy_on_done = 0;
            auto_rdy = 1;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_mask == 4'hF) begin
                if (!m_valid || out_ready) begin
                    for (int i = 0; i < NDIG; i++) begin
                        m_bcd[4*i +: 4] = m_sbcd[i];
                        m_blank[i] = m_sblank[i];
                        m_err[i]   = m_serr[i];
                    end
                    m_valid = 1'b1;
                end
                m_mask = 4'h0;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            idx = sel_index(pend_dig);
            if (idx < 0) begin
                run = 0;
            end else begin
                if (run > 0 && pend_seg == last_seg && pend_dig == last_dig) begin
                    if (run <= S) run++;
                end else begin
                    run = 1;
                end
                if (run == S) begin
                    dec = ref_decode(pend_seg);
                    m_sbcd[idx]   = dec[5:2];
                    m_sblank[idx] = dec[1];
                    m_serr[idx]   = dec[0];
                    m_mask[idx]   = 1'b1;
                end
            end
            last_seg = pend_seg; last_dig = pend_dig;
            pend_seg = seg_n;    pend_dig = dig_n;
        end
        #1;
        if (auto_rdy) out_ready = 1'b0;
        if (track_valid && !out_valid) valid_dropped = 1;
        chk("valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("bcd",   {16'd0, bcd_out},   {16'd0, m_bcd});
        chk("blank", {28'd0, blank_out}, {28'd0, m_blank});
        chk("err",   {28'd0, err_out},   {28'd0, m_err});
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [3:0] one;
        one   = 4'b0001;
        dig_n = ~(one << d);
        seg_n = s;
        repeat (n) tick();
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0);
        show(3, s3, 6); show(2, s2, 6); show(1, s1, 6); show(0, s0, 6);
    endtask

    task automatic accept();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("accept_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [6:0] pool [12];
        pool = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18, 7'h7F, 7'h55};
        model_reset();

        rst_n = 1'b0; repeat (3) tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bcd", {16'd0, bcd_out}, 32'd0);
        rst_n = 1'b1;

        // 1) basic frame
        frame(7'h30, 7'h24, 7'h79, 7'h40);
        chk("t1_bcd", {16'd0, bcd_out}, 32'h3210);
        chk("t1_blank", {28'd0, blank_out}, 32'd0);
        chk("t1_err", {28'd0, err_out}, 32'd0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        accept();

        // 2) short-lived pattern must not be captured
        show(3, 7'h18, 6); show(2, 7'h00, 6); show(1, 7'h78, 6);
        show(0, 7'h12, 3); show(0, 7'h02, 5);
        dig_n = 4'hF; tick(); tick();
        chk("t2_bcd", {16'd0, bcd_out}, 32'h9876);
        accept();

        // 3) blank and unrecognised patterns
        frame(7'h19, 7'h7F, 7'h55, 7'h40);
        chk("t3_bcd", {16'd0, bcd_out}, 32'h4FF0);
        chk("t3_blank", {28'd0, blank_out}, 32'h4);
        chk("t3_err", {28'd0, err_out}, 32'h2);
        accept();

        // 4) invalid selections capture nothing
        show(3, 7'h12, 6); show(2, 7'h02, 6);
        dig_n = 4'h0; seg_n = 7'h00; repeat (20) tick();
        dig_n = 4'hF; repeat (20) tick();
        chk("t4_nocap", {31'd0, out_valid}, 32'd0);
        show(1, 7'h79, 6); show(0, 7'h40, 6);
        chk("t4_bcd", {16'd0, bcd_out}, 32'h5610);
        accept();

        // 5) backpressure: second frame dropped, third loads on accept cycle
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("t5_first", {16'd0, bcd_out}, 32'h1234);
        track_valid = 1; valid_dropped = 0;
        frame(7'h12, 7'h02, 7'h78, 7'h00);
        chk("t5_drop", {16'd0, bcd_out}, 32'h1234);
        rdy_on_done = 1;
        frame(7'h18, 7'h40, 7'h79, 7'h24);
        track_valid = 0;
        chk("t5_third", {16'd0, bcd_out}, 32'h9012);
        chk("t5_held", {31'd0, valid_dropped}, 32'd0);
        accept();

        // 6) reset mid-frame discards partial captures
        show(3, 7'h30, 6); show(2, 7'h30, 6); show(1, 7'h30, 6);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_bcd", {16'd0, bcd_out}, 32'd0);
        chk("t6_blank", {28'd0, blank_out}, 32'd0);
        chk("t6_err", {28'd0, err_out}, 32'd0);
        show(2, 7'h24, 6); show(1, 7'h79, 6); show(0, 7'h40, 6);
        dig_n = 4'hF; repeat (3) tick();
        chk("t6_partial", {31'd0, out_valid}, 32'd0);
        show(3, 7'h19, 6);
        dig_n = 4'hF; tick();
        chk("t6_frame", {16'd0, bcd_out}, 32'h4210);
        accept();

        // Random scan traffic against the model
        for (int k = 0; k < 300; k++) begin
            logic [3:0] one;
            one = 4'b0001;
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) dig_n = ~(one << $urandom_range(0, NDIG - 1));
            else dig_n = 4'($urandom);
            seg_n = pool[$urandom_range(0, 11)];
            repeat ($urandom_range(1, 7)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
